// File: rtl/alu_seq.sv
// Sequential ALU: operands latched on start, multi-cycle execute, registered 32-bit result.
// Supports add, shift-add multiply, bitwise and, and bit-serial shift-left.
module alu_seq #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      functionSelect,
    input  logic [DW-1:0]   arin,
    input  logic [DW-1:0]   brin,
    output logic [2*DW-1:0] dataACC,
    output logic            busy,
    output logic            done
);

    localparam logic [3:0]    OP_ADD    = 4'b0001;
    localparam logic [3:0]    OP_MUL    = 4'b0011;
    localparam logic [3:0]    OP_AND    = 4'b0101;
    localparam logic [3:0]    OP_SHL    = 4'b1000;
    localparam logic [DW-1:0] SHL_LIMIT = DW'(2 * DW);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      func_reg;
    logic [DW-1:0]   a_reg, b_reg;
    logic [4:0]      cnt_reg;
    logic [2*DW-1:0] acc_reg;
    logic [2*DW-1:0] data_acc_reg;

    logic            accept, last;
    logic [4:0]      cnt_load;
    logic [4:0]      bit_idx;
    logic [2*DW-1:0] ext_a;
    logic [2*DW-1:0] acc_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg == 5'd1) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Number of EXEC cycles for the operation being accepted.
    always_comb begin
        cnt_load = 5'd1;
        if (functionSelect == OP_MUL) begin
            cnt_load = 5'(DW);
        end else if (functionSelect == OP_SHL && brin < SHL_LIMIT && brin != '0) begin
            cnt_load = brin[4:0];
        end
    end

    // Multiplier bit position walks LSB first as the counter runs down from DW.
    assign bit_idx = 5'(DW) - cnt_reg;
    assign ext_a   = {{DW{1'b0}}, a_reg};

    always_comb begin
        acc_step = '0;
        case (func_reg)
            OP_ADD: acc_step = {{(DW-1){1'b0}}, ({1'b0, a_reg} + {1'b0, b_reg})};
            OP_MUL: acc_step = b_reg[bit_idx[3:0]] ? (acc_reg + (ext_a << bit_idx)) : acc_reg;
            OP_AND: acc_step = {{DW{1'b0}}, a_reg & b_reg};
            OP_SHL: begin
                if (b_reg >= SHL_LIMIT) begin
                    acc_step = '0;
                end else if (b_reg == '0) begin
                    acc_step = acc_reg;
                end else begin
                    acc_step = acc_reg << 1;
                end
            end
            default: acc_step = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            func_reg     <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            data_acc_reg <= '0;
        end else if (accept) begin
            func_reg <= functionSelect;
            a_reg    <= arin;
            b_reg    <= brin;
            cnt_reg  <= cnt_load;
            acc_reg  <= (functionSelect == OP_SHL) ? {{DW{1'b0}}, arin} : '0;
        end else if (state_reg == EXEC) begin
            cnt_reg <= cnt_reg - 5'd1;
            acc_reg <= acc_step;
            // Only the final step is published; partial products stay internal.
            if (last) begin
                data_acc_reg <= acc_step;
            end
        end
    end

    assign dataACC = data_acc_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: result values, start-to-done latency, busy width,
// start-ignore while busy, and asynchronous reset abort.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  functionSelect = 4'd0;
    logic [15:0] arin = 16'd0;
    logic [15:0] brin = 16'd0;
    logic [31:0] dataACC;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    alu_seq #(.DW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .functionSelect (functionSelect),
        .arin           (arin),
        .brin           (brin),
        .dataACC        (dataACC),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge; the next edge is the accepting edge (edge 1).
    task automatic run_op(input string tag, input logic [3:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp_data,
                          input int exp_lat, input bit hold_start);
        logic [31:0] prev;
        int          done_edge;
        int          busy_cnt;
        bit          held_ok;
        prev      = dataACC;
        done_edge = 0;
        busy_cnt  = 0;
        held_ok   = 1'b1;
        functionSelect = f;
        arin  = a;
        brin  = b;
        start = 1'b1;
        for (int e = 1; e <= 60 && done_edge == 0; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                if (hold_start) begin
                    functionSelect = 4'b0001;
                    arin = 16'h0002;
                    brin = 16'h0003;
                end else begin
                    start = 1'b0;
                end
            end
            if (busy) busy_cnt++;
            if (done) done_edge = e;
            else if (dataACC !== prev) held_ok = 1'b0;
        end
        check({tag, " latency"}, 32'(done_edge), 32'(exp_lat));
        check({tag, " data"}, dataACC, exp_data);
        check({tag, " hold"}, {31'd0, held_ok}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " done width"}, {31'd0, done}, 32'd0);
        check({tag, " busy after"}, {31'd0, busy}, 32'd0);
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
        $display("op %s func=%b a=%h b=%h -> dataACC=%h latency=%0d", tag, f, a, b, dataACC, done_edge);
    endtask

    initial begin
        bit no_done;
        #2;
        check("reset data", dataACC, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("add",     4'b0001, 16'hFFFF, 16'h0001, 32'h0001_0000, 2, 1'b0);
        run_op("mul",     4'b0011, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17, 1'b0);
        run_op("shl4",    4'b1000, 16'h8001, 16'd4,    32'h0008_0010, 5, 1'b0);
        run_op("shl40",   4'b1000, 16'h8001, 16'd40,   32'h0000_0000, 2, 1'b0);
        run_op("shl0",    4'b1000, 16'h8001, 16'd0,    32'h0000_8001, 2, 1'b0);
        run_op("mulhold", 4'b0011, 16'h1234, 16'h5678, 32'h0626_0060, 17, 1'b1);
        run_op("add2",    4'b0001, 16'h0002, 16'h0003, 32'h0000_0005, 2, 1'b0);

        // Abort a multiply in its eighth EXEC cycle.
        functionSelect = 4'b0011;
        arin  = 16'hFFFF;
        brin  = 16'hFFFF;
        start = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2;
        rst = 1'b0;
        #1;
        check("rst data", dataACC, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        no_done = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) no_done = 1'b0;
        end
        check("rst no done", {31'd0, no_done}, 32'd1);
        $display("op rst-abort mul -> dataACC=%h", dataACC);

        run_op("and",     4'b0101, 16'hF0F0, 16'hFF00, 32'h0000_F000, 2, 1'b0);
        run_op("illegal", 4'b0111, 16'h1234, 16'h5678, 32'h0000_0000, 2, 1'b0);
        run_op("shl31",   4'b1000, 16'h0001, 16'd31,   32'h8000_0000, 32, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter DW, default 16, operand width; result width is 2*DW; only DW=16 is supported.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 functionSelect  input  4  operation code; latched with start.
REQ-006 arin  input  16  operand A; latched with start.
REQ-007 brin  input  16  operand B; latched with start.
REQ-008 dataACC  output  32  registered result, held until the next result or reset.
REQ-009 busy  output  1  high in EXEC and DONE.
REQ-010 done  output  1  high for exactly one cycle, in DONE.

Function
REQ-011 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-012 IDLE with start=1 at an edge: latch functionSelect/arin/brin, go to EXEC; IDLE with start=0: stay IDLE.
REQ-013 start SHALL be ignored in EXEC and DONE; latched operands SHALL NOT change until the next accepted start.
REQ-014 Code 0001 (add): result = zero-extended 17-bit arin+brin (carry in bit 16); 1 EXEC cycle.
REQ-015 Code 0011 (mul): unsigned 16x16 shift-add, one multiplier bit per cycle, LSB first; exactly 16 EXEC cycles.
REQ-016 Code 0101 (and): result = {16'h0, arin & brin}; 1 EXEC cycle.
REQ-017 Code 1000 (shl): result = {16'h0, arin} << brin, one bit per cycle; EXEC cycles = max(brin,1) when brin <= 31.
REQ-018 shl with brin >= 32 SHALL yield 0 in 1 EXEC cycle; brin = 0 SHALL yield {16'h0, arin} in 1 EXEC cycle.
REQ-019 Any other code SHALL yield 0 in 1 EXEC cycle.
REQ-020 The internal 5-bit iteration counter SHALL load at the accepting edge and decrement once per EXEC cycle.
REQ-021 EXEC SHALL exit to DONE at the edge where the counter reaches its final count.
REQ-022 dataACC SHALL update only on the edge entering DONE; intermediate partial values SHALL NOT appear on dataACC.
REQ-023 DONE SHALL last one cycle and then return to IDLE; a start present during DONE SHALL be ignored.
REQ-024 A start in the first IDLE cycle after DONE SHALL be accepted.
REQ-025 Start-to-done latency, counted in edges from the accepting edge to the edge raising done: N+1, where N = EXEC cycles.
REQ-026 Latencies SHALL be: add/and/other = 2, mul = 17, shl = max(brin,1)+1, or 2 for brin >= 32.
REQ-027 Back-to-back throughput: one operation per N+2 cycles.

Reset
REQ-028 rst low SHALL immediately force state IDLE and dataACC, busy, done, latched operands and counter to 0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL abort it with no done pulse; the first accepted start after rst rises SHALL behave as from power-up.

Verification
REQ-030 Add: start, func=0001, arin=FFFF, brin=0001 -> done 2 edges later, dataACC=0001_0000, busy high for 2 cycles.
REQ-031 Mul: func=0011, arin=FFFF, brin=FFFF -> done at edge 17, dataACC=FFFE_0001, dataACC unchanged in edges 1-16.
REQ-032 Shl: func=1000, arin=8001, brin=4 -> dataACC=0008_0010 at edge 5; repeat with brin=40 -> dataACC=0 at edge 2.
REQ-033 Start held high during a mul with new operands (arin=0002, brin=0003, func=0001) -> ignored; only the mul result appears; the next start is accepted the cycle after DONE.
REQ-034 rst low at EXEC cycle 8 of a mul -> dataACC/busy/done=0 asynchronously, no done pulse; after release, func=0101, arin=F0F0, brin=FF00 -> dataACC=0000_F000 at edge 2.
REQ-035 Illegal func=0111, arin=1234, brin=5678 -> dataACC=0 at edge 2, done pulse exactly 1 cycle wide.
